// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM: access sizes, FSM encoding and the
// memory-mapped peripheral register addresses.
package data_ram_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [31:0] MMIO_ADDR0 = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_ADDR1 = 32'hFFFF_0004;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_ram_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension,
// store byte enables and replicated store data, and alignment checking.
module data_ram_lane_align
    import data_ram_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        misalign
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        load_byte = 8'h00;
        case (addr_lo)
            2'd0:    load_byte = raw_word[7:0];
            2'd1:    load_byte = raw_word[15:8];
            2'd2:    load_byte = raw_word[23:16];
            default: load_byte = raw_word[31:24];
        endcase
        load_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        load_data  = raw_word;
        byte_en    = 4'b0000;
        store_data = wdata;
        misalign   = 1'b0;
        case (size)
            SIZE_B: begin
                load_data  = is_unsigned ? {24'h0, load_byte}
                                         : {{24{load_byte[7]}}, load_byte};
                byte_en    = 4'b0001 << addr_lo;
                store_data = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                load_data  = is_unsigned ? {16'h0, load_half}
                                         : {{16{load_half[15]}}, load_half};
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            SIZE_W: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Data RAM with request/response handshake and fixed WAIT_CYCLES latency.
// Optional peripheral registers at MMIO_ADDR0/1 are enabled by DATA_RAM_MMIO_EN.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
`ifdef DATA_RAM_MMIO_EN
    ,
    output logic [31:0] periph_out0,
    output logic [31:0] periph_out1,
    output logic        periph_wr0,
    output logic        periph_wr1
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic        cap_write, cap_unsigned;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_size;

    logic        accept, resp_entry;
    logic        cur_write, cur_unsigned;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic [IDX_W-1:0] idx;
    logic        range_err, err;
    logic        is_mmio0, is_mmio1, is_mmio;
    logic [31:0] raw_word, load_data, store_data;
    logic [3:0]  byte_en;
    logic        misalign;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_entry = (next_state == ST_RESP);

    // With zero wait cycles RESP is entered on the accepting edge itself, so
    // the access is evaluated from the live request instead of the capture.
    assign cur_write    = req_ready ? req_write    : cap_write;
    assign cur_addr     = req_ready ? req_addr     : cap_addr;
    assign cur_wdata    = req_ready ? req_wdata    : cap_wdata;
    assign cur_size     = req_ready ? req_size     : cap_size;
    assign cur_unsigned = req_ready ? req_unsigned : cap_unsigned;

    assign idx = cur_addr[IDX_W+1:2];

`ifdef DATA_RAM_MMIO_EN
    assign is_mmio0 = (cur_addr == MMIO_ADDR0);
    assign is_mmio1 = (cur_addr == MMIO_ADDR1);
`else
    assign is_mmio0 = 1'b0;
    assign is_mmio1 = 1'b0;
`endif
    assign is_mmio = is_mmio0 || is_mmio1;

    always_comb begin
        raw_word = mem[idx];
`ifdef DATA_RAM_MMIO_EN
        if (is_mmio0) raw_word = periph_out0;
        if (is_mmio1) raw_word = periph_out1;
`endif
    end

    assign range_err = (cur_addr[31:IDX_W+2] != '0) && !is_mmio;
    assign err = (cur_size == 2'b11) || misalign || range_err
              || (is_mmio && (cur_size != SIZE_W));

    data_ram_lane_align u_align (
        .addr_lo     (cur_addr[1:0]),
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .raw_word    (raw_word),
        .wdata       (cur_wdata),
        .load_data   (load_data),
        .byte_en     (byte_en),
        .store_data  (store_data),
        .misalign    (misalign)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            cap_write    <= 1'b0;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
            cap_size     <= SIZE_B;
            cap_unsigned <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_error   <= 1'b0;
        end else begin
            state      <= next_state;
            resp_valid <= resp_entry;
            if (accept) begin
                cap_write    <= req_write;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                if (WAIT_CYCLES > 0) wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (resp_entry) begin
                resp_error <= err;
                resp_rdata <= (err || cur_write) ? 32'h0 : load_data;
            end
        end
    end

    // Array has no reset; only an error-free store commits, on RESP entry.
    always_ff @(posedge clk) begin
        if (resp_entry && cur_write && !err && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

`ifdef DATA_RAM_MMIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periph_out0 <= 32'h0;
            periph_out1 <= 32'h0;
            periph_wr0  <= 1'b0;
            periph_wr1  <= 1'b0;
        end else begin
            periph_wr0 <= resp_entry && cur_write && !err && is_mmio0;
            periph_wr1 <= resp_entry && cur_write && !err && is_mmio1;
            if (resp_entry && cur_write && !err && is_mmio0) periph_out0 <= cur_wdata;
            if (resp_entry && cur_write && !err && is_mmio1) periph_out1 <= cur_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (WAIT_CYCLES = 2): table-driven vectors
// with a response scoreboard plus hand-written reset and MMIO sequences.
module tb_data_ram;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_error, busy;
    logic [31:0] resp_rdata;
`ifdef DATA_RAM_MMIO_EN
    logic [31:0] periph_out0, periph_out1;
    logic        periph_wr0, periph_wr1;
    int          wr1_pulses = 0;
    always @(negedge clk) if (periph_wr1) wr1_pulses++;
`endif

    always #5 clk = ~clk;

    data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT), .INIT_FILE("")) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy)
`ifdef DATA_RAM_MMIO_EN
        ,
        .periph_out0  (periph_out0),
        .periph_out1  (periph_out1),
        .periph_wr0   (periph_wr0),
        .periph_wr1   (periph_wr1)
`endif
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_error;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void add(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                                logic u, logic [31:0] er, logic ee, string n);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
        v.exp_rdata = er; v.exp_error = ee; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, resp_rdata, e.rdata);
            check({e.name, "_error"}, {31'h0, resp_error}, {31'h0, e.error});
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int  n;
        bit  got;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({v.name, "_ready_timeout"}, 32'd0, 32'd1);
        req_write    = v.write;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_valid    = 1'b1;
        sb.push_back('{v.exp_rdata, v.exp_error, v.name});
        @(posedge clk);
        #1;
        // Scramble the request lines to show they are not resampled.
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        got = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                check({v.name, "_latency"}, c, WAIT + 1);
                got = 1'b1;
                break;
            end
            if (req_ready) check({v.name, "_ready_low"}, {31'h0, req_ready}, 32'd0);
        end
        if (!got) begin
            check({v.name, "_resp_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            check({v.name, "_ready_in_resp"}, {31'h0, req_ready}, 32'd0);
            checkOutput();
            @(negedge clk);
            check({v.name, "_pulse_len"}, {31'h0, resp_valid}, 32'd0);
            check({v.name, "_hold"}, resp_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        vec_t v;
        int   stray;
`ifdef DATA_RAM_MMIO_EN
        int   pulses_before;
`endif
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_error", {31'h0, resp_error}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //  wr  addr          wdata         size   uns expected      err
        add(1, 32'h10,       32'hDEADBEEF, 2'b10, 0, 32'h0,        0, "sw_10");
        add(0, 32'h10,       32'h0,        2'b10, 0, 32'hDEADBEEF, 0, "lw_10");
        add(1, 32'h10,       32'h0,        2'b10, 0, 32'h0,        0, "sw_10_clr");
        add(1, 32'h11,       32'h80,       2'b00, 0, 32'h0,        0, "sb_11");
        add(0, 32'h11,       32'h0,        2'b00, 0, 32'hFFFFFF80, 0, "lb_11");
        add(0, 32'h11,       32'h0,        2'b00, 1, 32'h00000080, 0, "lbu_11");
        add(0, 32'h10,       32'h0,        2'b10, 0, 32'h00008000, 0, "lw_10_b");
        add(0, 32'h13,       32'h0,        2'b01, 0, 32'h0,        1, "lh_13_mis");
        add(1, 32'h12,       32'hFFFFFFFF, 2'b10, 0, 32'h0,        1, "sw_12_mis");
        add(0, 32'h10,       32'h0,        2'b10, 0, 32'h00008000, 0, "lw_10_c");
        add(0, 32'h1000,     32'h0,        2'b10, 0, 32'h0,        1, "lw_range");
        add(0, 32'h10,       32'h0,        2'b11, 0, 32'h0,        1, "size_ill");
        add(1, 32'h14,       32'h11223344, 2'b10, 0, 32'h0,        0, "sw_14");
        add(1, 32'h16,       32'hABCD1234, 2'b01, 0, 32'h0,        0, "sh_16");
        add(1, 32'h14,       32'h000000F0, 2'b00, 0, 32'h0,        0, "sb_14");
        add(0, 32'h14,       32'h0,        2'b10, 0, 32'h123433F0, 0, "lw_14");
        add(0, 32'h14,       32'h0,        2'b00, 0, 32'hFFFFFFF0, 0, "lb_14");
        add(0, 32'h17,       32'h0,        2'b00, 0, 32'h00000012, 0, "lb_17");
        add(0, 32'h14,       32'h0,        2'b01, 1, 32'h000033F0, 0, "lhu_14");
        add(0, 32'h16,       32'h0,        2'b01, 0, 32'h00001234, 0, "lh_16");
        add(1, 32'h18,       32'h8000F001, 2'b10, 0, 32'h0,        0, "sw_18");
        add(0, 32'h18,       32'h0,        2'b01, 0, 32'hFFFFF001, 0, "lh_18");
        add(0, 32'h18,       32'h0,        2'b10, 1, 32'h8000F001, 0, "lwu_18");
        add(1, 32'hFFC,      32'hCAFEF00D, 2'b10, 0, 32'h0,        0, "sw_last");
        add(0, 32'hFFC,      32'h0,        2'b10, 0, 32'hCAFEF00D, 0, "lw_last");
        add(1, 32'h20,       32'h0BADF00D, 2'b10, 0, 32'h0,        0, "sw_20");
        add(0, 32'hFFFF0000, 32'h0,        2'b01, 0, 32'h0,        1, "lh_mmio");
`ifdef DATA_RAM_MMIO_EN
        add(1, 32'hFFFF0000, 32'h00001234, 2'b10, 0, 32'h0,        0, "sw_mmio0");
        add(0, 32'hFFFF0000, 32'h0,        2'b10, 0, 32'h00001234, 0, "lw_mmio0");
        add(1, 32'hFFFF0004, 32'h000000FF, 2'b00, 0, 32'h0,        1, "sb_mmio1");
`else
        add(0, 32'hFFFF0000, 32'h0,        2'b10, 0, 32'h0,        1, "lw_mmio0");
`endif

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", {31'h0, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check("mid_no_resp", stray, 0);
        check("mid_ready", {31'h0, req_ready}, 32'd1);
        v.write = 0; v.addr = 32'h20; v.wdata = 0; v.size = 2'b10; v.uns = 0;
        v.exp_rdata = 32'h0BADF00D; v.exp_error = 0; v.name = "lw_20_after_rst";
        applyStimulus(v);

        v.write = 1; v.addr = 32'hFFFF0004; v.wdata = 32'hA5; v.size = 2'b10; v.uns = 0;
        v.exp_rdata = 32'h0; v.name = "sw_mmio1";
`ifdef DATA_RAM_MMIO_EN
        v.exp_error = 0;
        pulses_before = wr1_pulses;
        applyStimulus(v);
        check("mmio_wr1_pulses", wr1_pulses - pulses_before, 1);
        check("mmio_out1", periph_out1, 32'hA5);
        v.write = 0; v.wdata = 0; v.exp_rdata = 32'hA5; v.name = "lw_mmio1";
        applyStimulus(v);
`else
        v.exp_error = 1;
        applyStimulus(v);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
